// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared definitions for the handshake arbiter family: width helper,
// arbitration state encoding and the default beat width.
package handshake_pkg;

    localparam int HS_DW = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Number of bits needed to index n entries (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// Bundle of the N master-side channels and the single downstream channel.
// The "master" modport is the traffic side (sources plus downstream sink),
// the "slave" modport is the arbiter's own view of the same wires.
interface handshake_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = handshake_pkg::HS_DW,
    parameter int IW = handshake_pkg::clog2(N)
);
    logic [N-1:0]    master_valid;
    logic [N*DW-1:0] master_data;
    logic [N-1:0]    master_last;
    logic [N-1:0]    master_ready;
    logic            slave_valid;
    logic [DW-1:0]   slave_data;
    logic [IW-1:0]   slave_id;
    logic            slave_last;
    logic            slave_ready;

    modport master (
        output master_valid, master_data, master_last, slave_ready,
        input  master_ready, slave_valid, slave_data, slave_id, slave_last
    );

    modport slave (
        input  master_valid, master_data, master_last, slave_ready,
        output master_ready, slave_valid, slave_data, slave_id, slave_last
    );
endinterface

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping modulo N. Purely combinational so other arbiters can reuse it.
module rr_pick import handshake_pkg::*; #(
    parameter  int N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);
    int            pos;
    logic [IW-1:0] cand;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        pos  = 0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            cand = IW'(pos);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready stage among N
// masters. Bursts keep the grant until their last beat; the pointer only
// advances when a burst completes.
module handshake_rr_arbiter import handshake_pkg::*; #(
    parameter int N  = 4,
    parameter int DW = HS_DW,
    parameter int IW = clog2(N)
) (
    input logic                   clk,
    input logic                   rst_n,
    handshake_rr_arbiter_if.slave bus
);
    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr, rr_ptr_d;
    logic [IW-1:0] lock_idx, lock_idx_d;
    logic [IW-1:0] pick_idx, grant_idx;
    logic          pick_any, grant_ok;
    logic          free, m_hs;
    logic          beat_valid, beat_last;
    logic [DW-1:0] beat_data;
    logic [N-1:0]  ready_vec;

    logic          vld_p0;
    logic [DW-1:0] data_p0;
    logic [IW-1:0] id_p0;
    logic          last_p0;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N)) u_pick (
        .req (bus.master_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant source: the rotating pick while idle, the burst owner while locked.
    always_comb begin
        grant_idx = pick_idx;
        grant_ok  = pick_any;
        if (state_q == ARB_LOCK) begin
            grant_idx = lock_idx;
            grant_ok  = 1'b1;
        end
    end

    // Select the granted master's beat and derive ready / handshake.
    always_comb begin
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_data  = '0;
        ready_vec  = '0;
        free       = bus.slave_ready | ~vld_p0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IW'(i)) begin
                beat_valid   = bus.master_valid[i];
                beat_last    = bus.master_last[i];
                beat_data    = bus.master_data[i*DW +: DW];
                ready_vec[i] = free & grant_ok;
            end
        end
        m_hs = free & grant_ok & beat_valid;
    end

    // Arbitration next-state: lock on a non-final beat, release and rotate on the last.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr;
        lock_idx_d = lock_idx;
        case (state_q)
            ARB_IDLE: begin
                if (m_hs) begin
                    if (beat_last) begin
                        rr_ptr_d = ptr_inc(grant_idx);
                    end else begin
                        state_d    = ARB_LOCK;
                        lock_idx_d = grant_idx;
                    end
                end
            end
            ARB_LOCK: begin
                if (m_hs && beat_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ptr_inc(lock_idx);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Arbitration state, pointer and lock owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_ptr_d;
            lock_idx <= lock_idx_d;
        end
    end

    // ---- stage p0: output register; a new beat overrides a concurrent drain ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            id_p0   <= '0;
            last_p0 <= 1'b0;
        end else if (m_hs) begin
            vld_p0  <= 1'b1;
            data_p0 <= beat_data;
            id_p0   <= grant_idx;
            last_p0 <= beat_last;
        end else if (vld_p0 && bus.slave_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign bus.master_ready = ready_vec;
    assign bus.slave_valid  = vld_p0;
    assign bus.slave_data   = data_p0;
    assign bus.slave_id     = id_p0;
    assign bus.slave_last   = last_p0;
endmodule
